// File: rtl/spi_reg_pkg.sv
// Shared definitions for the register-bank SPI initiator: register map,
// FSM state encoding and set/clear/toggle value encoders.
package spi_reg_pkg;

  localparam logic [7:0] REG_LED        = 8'd7;
  localparam logic [7:0] REG_SOFT_RESET = 8'd11;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_e;

  // The slave decodes the low nibble as bits to set, the high nibble as bits
  // to clear, and equal non-zero nibbles as bits to toggle.
  function automatic logic [7:0] SET(input logic [3:0] n);
    return {4'h0, n};
  endfunction

  function automatic logic [7:0] CLR(input logic [3:0] n);
    return {n, 4'h0};
  endfunction

  function automatic logic [7:0] TOG(input logic [3:0] n);
    return {n, n};
  endfunction

endpackage

// File: rtl/spi_reg_master_if.sv
// Request/response handshake plus the SPI pins of the register-bank initiator.
interface spi_reg_master_if;

  logic        start;
  logic [7:0]  addr;
  logic [7:0]  val;
  logic        busy;
  logic        done;
  logic [15:0] rdata;
  logic        spi_clk;
  logic        spi_cs;
  logic        spi_special;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  start, addr, val, spi_miso,
    output busy, done, rdata, spi_clk, spi_cs, spi_special, spi_mosi
  );

  modport slave (
    output start, addr, val, spi_miso,
    input  busy, done, rdata, spi_clk, spi_cs, spi_special, spi_mosi
  );

endinterface

// File: rtl/spi_half_tick.sv
// Half-period timer: counts 0..CLK_DIV-1 and strobes tick on the last count.
module spi_half_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Every non-idle state change happens on a tick, where the count wraps to
  // zero anyway, so holding it cleared while idle restarts each phase cleanly.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || restart || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/spi_reg_master.sv
// SPI initiator for the register-bank slave: one 16-bit {addr,val} frame per
// accepted start, MSB first, capturing the 16 bits returned on miso.
module spi_reg_master
  import spi_reg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int MSB     = 16
) (
  input logic              clk,
  input logic              rst,
  spi_reg_master_if.master bus
);

  localparam logic [4:0] FRAME_LEN = 5'(MSB);

  state_e         state_q, state_d;
  logic [MSB-1:0] shreg_q, shreg_d;
  logic [MSB-1:0] rshift_q, rshift_d;
  logic [MSB-1:0] rdata_q, rdata_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           sclk_q, sclk_d;
  logic           cs_q, cs_d;
  logic           mosi_q, mosi_d;
  logic           miso_meta, miso_sync;
  logic           idle;
  logic           tick;

  assign idle = (state_q == IDLE);

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (idle),
    .tick    (tick)
  );

  // miso comes from the slave's clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= bus.spi_miso;
      miso_sync <= miso_meta;
    end
  end

  // NOTE: every signal is given its hold value before the case so that no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rshift_d  = rshift_q;
    rdata_d   = rdata_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shreg_d   = {bus.addr, bus.val};
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          cs_d      = 1'b0;
          mosi_d    = bus.addr[7];
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = HIGH;
        end
      end
      HIGH: begin
        // The slave samples mosi on this falling edge.
        if (tick) begin
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 5'd1;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (tick) begin
          rshift_d = {rshift_q[MSB-2:0], miso_sync};
          if (bit_cnt_q < FRAME_LEN) begin
            shreg_d = {shreg_q[MSB-2:0], 1'b0};
            mosi_d  = shreg_q[MSB-2];
            sclk_d  = 1'b1;
            state_d = HIGH;
          end else begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Rising cs is the slave's latch event.
        if (tick) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          rdata_d = rshift_q;
          done_d  = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
    end
  end

  // NOTE: the shift registers are fully reloaded or overwritten before any
  // bit of them is observed, so they carry no reset.
  always_ff @(posedge clk) begin
    shreg_q  <= shreg_d;
    rshift_q <= rshift_d;
  end

  // A reset that aborts a frame in flight keeps the last completed readback.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (!busy_q) rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.spi_clk     = sclk_q;
  assign bus.spi_cs      = cs_q;
  assign bus.spi_special = cs_q;
  assign bus.spi_mosi    = mosi_q;

endmodule

// File: tb/tb_spi_reg_master.sv
// Bench for spi_reg_master: a divide-by-4 instance checked against a frame
// scoreboard and a divide-by-2 instance driving a register-bank slave model.
module tb_spi_reg_master;
  import spi_reg_pkg::*;

  localparam int D4 = 4;

  typedef struct {
    logic [15:0] frame;
    logic [15:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  exp_t       exp_q[$];
  logic [3:0] led_q[$];
  logic [15:0] last_rdata = 16'h0000;

  spi_reg_master_if if4 ();
  spi_reg_master_if if2 ();

  spi_reg_master #(.CLK_DIV(D4), .MSB(16)) dut4 (.clk(clk), .rst(rst), .bus(if4.master));
  spi_reg_master #(.CLK_DIV(2),  .MSB(16)) dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  always #5 clk = ~clk;

  // Slave-side monitor for the divide-by-4 instance: records mosi on each
  // falling sclk and shifts miso_pat4 out, updating on falling edges.
  logic [15:0] miso_pat4    = 16'h0000;
  logic [15:0] mosi_cap4    = 16'h0000;
  logic [15:0] frame_mosi4  = 16'h0000;
  int          falls4       = 0;
  int          frame_falls4 = 0;

  always @(negedge if4.spi_clk or posedge if4.spi_cs) begin
    if (if4.spi_cs !== 1'b0) begin
      frame_mosi4  = mosi_cap4;
      frame_falls4 = falls4;
      mosi_cap4    = 16'h0000;
      falls4       = 0;
      if4.spi_miso = 1'b0;
    end else begin
      mosi_cap4 = {mosi_cap4[14:0], if4.spi_mosi};
      falls4++;
      if (falls4 <= 16) if4.spi_miso = miso_pat4[16 - falls4];
    end
  end

  // Register-bank slave model for the divide-by-2 instance.
  logic [15:0] sr2     = 16'h0000;
  int          cnt2    = 0;
  logic [3:0]  reg_led = 4'h0;

  function automatic logic [3:0] apply_val(input logic [3:0] cur, input logic [7:0] v);
    if (v[7:4] == v[3:0]) return cur ^ v[3:0];
    return (cur | v[3:0]) & ~v[7:4];
  endfunction

  always @(negedge if2.spi_clk or posedge if2.spi_cs) begin
    if (if2.spi_cs !== 1'b0) begin
      if (cnt2 == 16 && sr2[15:8] == REG_LED) reg_led = apply_val(reg_led, sr2[7:0]);
      cnt2 = 0;
    end else begin
      sr2 = {sr2[14:0], if2.spi_mosi};
      cnt2++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic service_done4();
    exp_t e;
    check("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("mosi_frame", frame_mosi4, e.frame);
    check("rdata", if4.rdata, e.rdata);
    check("falling_edges", frame_falls4, 16);
    last_rdata = e.rdata;
  endtask

  // One frame on the divide-by-4 instance; mid >= 0 pulses start while busy.
  task automatic do_frame4(input logic [7:0] a, input logic [7:0] v,
                           input logic [15:0] pat, input int mid);
    int cs_low = 0;
    int busy_cyc = 0;
    int dones = 0;
    int cyc = 0;
    int extra = 0;
    miso_pat4 = pat;
    exp_q.push_back('{frame: {a, v}, rdata: pat});
    if4.addr  = a;
    if4.val   = v;
    if4.start = 1'b1;
    @(negedge clk);
    while (if4.busy && cyc < 400) begin
      if4.start = (cyc == mid);
      if (!if4.spi_cs) cs_low++;
      busy_cyc++;
      if (if4.done) begin
        dones++;
        service_done4();
      end
      cyc++;
      @(negedge clk);
    end
    if4.start = 1'b0;
    check("frame_in_budget", cyc < 400, 1);
    check("cs_low_cycles", cs_low, 34 * D4);
    check("busy_cycles", busy_cyc, 35 * D4);
    check("done_pulses", dones, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if4.busy || !if4.spi_cs) extra++;
    end
    check("no_extra_frame", extra, 0);
  endtask

  task automatic frame2(input logic [7:0] a, input logic [7:0] v, input logic [3:0] exp_led);
    int cyc = 0;
    bit seen = 1'b0;
    led_q.push_back(exp_led);
    if2.addr  = a;
    if2.val   = v;
    if2.start = 1'b1;
    @(negedge clk);
    if2.start = 1'b0;
    while (if2.busy && cyc < 200) begin
      if (if2.done) seen = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("d2_done_seen", seen, 1);
    check("d2_reg_led", reg_led, led_q.pop_front());
  endtask

  initial begin
    int cyc;
    int dones;
    int gap;
    int min_gap;
    int stray;
    bit seen_low;

    if4.start = 1'b0; if4.addr = 8'h00; if4.val = 8'h00;
    if2.start = 1'b0; if2.addr = 8'h00; if2.val = 8'h00; if2.spi_miso = 1'b0;

    // Reset idle levels.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs", if4.spi_cs, 1);
    check("rst_special", if4.spi_special, 1);
    check("rst_sclk", if4.spi_clk, 0);
    check("rst_mosi", if4.spi_mosi, 0);
    check("rst_busy", if4.busy, 0);
    check("rst_done", if4.done, 0);
    check("rst_rdata", if4.rdata, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Basic LED write, with a start pulse mid-frame that must be ignored.
    do_frame4(REG_LED, 8'h03, 16'h0000, 50);

    // Readback of a pattern driven by the slave model.
    do_frame4(8'h3C, 8'hC3, 16'hA55A, -1);

    // Start held high for three back-to-back frames.
    for (int i = 0; i < 3; i++) exp_q.push_back('{frame: {REG_LED, TOG(4'h9)}, rdata: 16'h1234});
    miso_pat4 = 16'h1234;
    if4.addr  = REG_LED;
    if4.val   = TOG(4'h9);
    if4.start = 1'b1;
    cyc = 0; dones = 0; gap = 0; min_gap = 1000; seen_low = 1'b0;
    while (dones < 3 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (if4.spi_cs) begin
        gap++;
      end else begin
        if (seen_low && gap > 0 && gap < min_gap) min_gap = gap;
        gap = 0;
        seen_low = 1'b1;
      end
      if (if4.done) begin
        dones++;
        service_done4();
      end
    end
    if4.start = 1'b0;
    check("b2b_done_pulses", dones, 3);
    check("b2b_cs_high_gap", min_gap, D4 + 1);
    cyc = 0;
    while (if4.busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b_settled", if4.busy, 0);

    // Abort with reset after the eighth falling edge.
    miso_pat4 = 16'hFFFF;
    if4.addr  = 8'h55;
    if4.val   = 8'hAA;
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    cyc = 0;
    while (falls4 < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_8", falls4, 8);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs", if4.spi_cs, 1);
    check("abort_special", if4.spi_special, 1);
    check("abort_sclk", if4.spi_clk, 0);
    check("abort_busy", if4.busy, 0);
    check("abort_done", if4.done, 0);
    check("abort_rdata", if4.rdata, last_rdata);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (if4.done || if4.busy) stray++;
    end
    check("abort_quiet", stray, 0);

    // Soft-reset frame after the abort must be bit-exact.
    do_frame4(REG_SOFT_RESET, 8'h00, 16'h5AA5, -1);
    check("sb_drained", exp_q.size(), 0);

    // Minimum divider against the register-bank slave model.
    frame2(REG_LED, SET(4'b0101), 4'b0101);
    frame2(REG_LED, TOG(4'b0011), 4'b0110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
